// File: rtl/alu_rr_scheduler.sv
// ============================================================================
// alu_rr_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one registered ALU (1-cycle latency) among NUM_REQ requesters.
//   A round-robin arbiter picks one requester at a time, issues its operands
//   to the ALU, captures the result and presents it as a tagged response that
//   the consumer can back-pressure. Only one operation is in flight at a time:
//     IDLE -> EXEC -> CAPT -> RESP -> IDLE
//   Accept edge T0 gives rsp_valid high in cycle T0+3, so the best-case
//   throughput is one operation every four cycles.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   ALU operand width
//   OP_W     ALU opcode width
//   RES_W    ALU result width
//   ID_W     requester tag width (derived)
//
// Ports:
//   clk         in   clock, all logic on posedge
//   rst         in   synchronous, active-high reset
//   req_valid   in   per-requester operation valid
//   req_a       in   packed operand a, requester i at [i*DATA_W +: DATA_W]
//   req_b       in   packed operand b, same packing
//   req_sel     in   packed opcode, requester i at [i*OP_W +: OP_W]
//   req_ready   out  one-hot accept, only ever high in IDLE
//   alu_a       out  registered operand a to the ALU
//   alu_b       out  registered operand b to the ALU
//   alu_sel     out  registered opcode to the ALU
//   alu_result  in   registered ALU result
//   rsp_valid   out  response valid
//   rsp_id      out  index of the requester that owns rsp_result
//   rsp_result  out  captured ALU result, passed through unmodified
//   rsp_ready   in   response consumer ready
//   busy        out  high whenever the sequencer is not IDLE
// ============================================================================
module alu_rr_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 4,
    parameter  int OP_W    = 3,
    parameter  int RES_W   = 6,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    input  logic [NUM_REQ*OP_W-1:0]    req_sel,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [OP_W-1:0]            alu_sel,
    input  logic [RES_W-1:0]           alu_result,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [RES_W-1:0]           rsp_result,
    input  logic                       rsp_ready,
    output logic                       busy
);

    // ------------------------------------------------------------------------
    // Sequencer states
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;  // arbitrate and accept
    localparam logic [1:0] ST_EXEC = 2'd1;  // ALU registers its result
    localparam logic [1:0] ST_CAPT = 2'd2;  // capture ALU result into response
    localparam logic [1:0] ST_RESP = 2'd3;  // hold response until consumed

    // One extra bit so ptr + k (k up to NUM_REQ) never overflows before wrap.
    localparam int SUM_W = ID_W + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic [ID_W-1:0]   ptr_q,        ptr_d;       // last granted requester
    logic [ID_W-1:0]   tag_q,        tag_d;       // owner of the op in flight
    logic [DATA_W-1:0] alu_a_q,      alu_a_d;
    logic [DATA_W-1:0] alu_b_q,      alu_b_d;
    logic [OP_W-1:0]   alu_sel_q,    alu_sel_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
    logic [RES_W-1:0]  rsp_result_q, rsp_result_d;

    // ------------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------------
    // Search starts just after the last grant and wraps, so the requester
    // granted last has the lowest priority next time. Idle requesters are
    // simply skipped, so no arbitration slot is ever wasted on them.
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [SUM_W-1:0]  cand_sum;
    logic [ID_W-1:0]   cand_idx;

    // NOTE: every variable written in a combinational block gets a default at
    // the top; any path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + SUM_W'(k);
            if (cand_sum >= SUM_W'(NUM_REQ)) begin
                cand_sum = cand_sum - SUM_W'(NUM_REQ);
            end
            cand_idx = cand_sum[ID_W-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // The accept is only offered while IDLE; since the winner is by
    // construction a valid requester, offering it is the same as a transfer.
    logic accept;
    assign accept = (state_q == ST_IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        tag_d        = tag_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;

        case (state_q)
            ST_IDLE: begin
                // alu_* keep the previously issued operands until a new accept.
                if (accept) begin
                    alu_a_d   = req_a[int'(grant_idx) * DATA_W +: DATA_W];
                    alu_b_d   = req_b[int'(grant_idx) * DATA_W +: DATA_W];
                    alu_sel_d = req_sel[int'(grant_idx) * OP_W +: OP_W];
                    tag_d     = grant_idx;
                    ptr_d     = grant_idx;
                    state_d   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Operands are held stable while the ALU registers its result.
                state_d = ST_CAPT;
            end

            ST_CAPT: begin
                rsp_result_d = alu_result;
                rsp_id_d     = tag_q;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end

            ST_RESP: begin
                // A request arriving in the retire cycle is not seen until the
                // following IDLE cycle, because req_ready is low here.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, matching hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins from any state; an op in flight is silently dropped.
            state_q      <= ST_IDLE;
            ptr_q        <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
            tag_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tag_q        <= tag_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
